// File: rtl/flappy_pkg.sv
// Shared Flappy Bird types and constants for the pipe field.
// Holds the default coordinate geometry, the field FSM states and a random-rotate helper.
package flappy_pkg;

   localparam int X_W      = 11;
   localparam int SCREEN_W = 640;

   typedef logic [X_W-1:0] coord_t;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      IDLE = 2'd1,
      RUN  = 2'd2
   } field_state_e;

   // Rotate a 10-bit LFSR value left by n, so each slot draws a different gap from one random word.
   function automatic logic [9:0] rotl10(input logic [9:0] v, input int n);
      logic [19:0] d;
      d = {v, v} << (n % 10);
      return d[19:10];
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipe obstacle: x/y registers, initial load, scroll/respawn and bird-crossing detection.
// A slot sitting at x==0 respawns on its next scroll instead of moving.
module pipe_slot
   import flappy_pkg::*;
#(
   parameter int SLOT_IDX  = 0,
   parameter int NUM_PIPES = 2,
   parameter int X_W       = 11,
   parameter int SCREEN_W  = 640,
   parameter int GAP_BASE  = 200,
   parameter int GAP_BITS  = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load_i,
   input  logic           clear_i,
   input  logic           scroll_i,
   input  logic [2:0]     speed_i,
   input  logic [9:0]     random_i,
   input  logic [X_W-1:0] bird_x_i,
   output logic [X_W-1:0] x_o,
   output logic [X_W-1:0] y_o,
   output logic           valid_o,
   output logic           cross_o
);

   localparam logic [X_W-1:0] X_INIT    = X_W'((SLOT_IDX + 1) * (SCREEN_W / NUM_PIPES) - 1);
   localparam logic [X_W-1:0] X_RESPAWN = X_W'(SCREEN_W - 1);
   localparam logic [X_W-1:0] Y_BASE    = X_W'(GAP_BASE);

   logic [X_W-1:0] x_q, x_d;
   logic [X_W-1:0] y_q, y_d;
   logic           valid_q, valid_d;

   logic [9:0]     rot;
   logic [X_W-1:0] y_new;
   logic [X_W-1:0] speed_x;
   logic [X_W-1:0] x_next;
   logic           respawn;

   assign rot     = rotl10(random_i, SLOT_IDX);
   assign y_new   = Y_BASE + X_W'(rot[GAP_BITS-1:0]);
   assign speed_x = X_W'(speed_i);
   assign respawn = (x_q == '0);

   // Clamp at zero instead of wrapping when the step exceeds the remaining distance.
   always_comb begin
      x_next = x_q - speed_x;
      if (respawn) begin
         x_next = X_RESPAWN;
      end else if (x_q < speed_x) begin
         x_next = '0;
      end
   end

   assign cross_o = scroll_i && !respawn && (x_q > bird_x_i) && (x_next <= bird_x_i);

   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      valid_d = valid_q;
      if (clear_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         x_d     = X_INIT;
         y_d     = y_new;
         valid_d = 1'b1;
      end else if (scroll_i) begin
         x_d = x_next;
         if (respawn) begin
            y_d = y_new;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q     <= '0;
         y_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         valid_q <= valid_d;
      end
   end

   assign x_o     = x_q;
   assign y_o     = y_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/pipe_field_manager.sv
// Pipe field manager: sequences slot loading, scrolls the field on game ticks and
// turns bird crossings into pass pulses, a saturating pass count and a rising scroll speed.
module pipe_field_manager
   import flappy_pkg::*;
#(
   parameter int NUM_PIPES  = 2,
   parameter int X_W        = 11,
   parameter int SCREEN_W   = 640,
   parameter int GAP_BASE   = 200,
   parameter int GAP_BITS   = 8,
   parameter int SPEED_MAX  = 4,
   parameter int SPEED_STEP = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     tick,
   input  logic                     enable,
   input  logic                     restart,
   input  logic [9:0]               random,
   input  logic [X_W-1:0]           bird_x,
   output logic [NUM_PIPES*X_W-1:0] pipe_x,
   output logic [NUM_PIPES*X_W-1:0] pipe_y,
   output logic [NUM_PIPES-1:0]     pipe_valid,
   output logic                     pass,
   output logic [9:0]               pass_count,
   output logic [2:0]               speed
);

   localparam int IDX_W  = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
   localparam int STEP_W = $clog2(SPEED_STEP + NUM_PIPES);

   field_state_e      state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [9:0]        pc_q, pc_d;
   logic [2:0]        speed_q, speed_d;
   logic              pass_q, pass_d;

   logic [NUM_PIPES-1:0] load_vec;
   logic [NUM_PIPES-1:0] cross_vec;
   logic                 scroll;
   logic [3:0]           inc;
   logic [STEP_W-1:0]    step_sum;

   function automatic logic [9:0] sat_add_count(input logic [9:0] a, input logic [3:0] b);
      logic [10:0] s;
      s = {1'b0, a} + 11'(b);
      return s[10] ? 10'h3FF : s[9:0];
   endfunction

   // Restart blocks both loading and scrolling in its own cycle.
   assign scroll = !restart && tick && enable && (state_q != LOAD);

   for (genvar i = 0; i < NUM_PIPES; i++) begin : g_slot
      assign load_vec[i] = !restart && (state_q == LOAD) && (idx_q == IDX_W'(i));

      pipe_slot #(
         .SLOT_IDX (i),
         .NUM_PIPES(NUM_PIPES),
         .X_W      (X_W),
         .SCREEN_W (SCREEN_W),
         .GAP_BASE (GAP_BASE),
         .GAP_BITS (GAP_BITS)
      ) u_slot (
         .clk     (clk),
         .rst_n   (reset),
         .load_i  (load_vec[i]),
         .clear_i (restart),
         .scroll_i(scroll),
         .speed_i (speed_q),
         .random_i(random),
         .bird_x_i(bird_x),
         .x_o     (pipe_x[i*X_W +: X_W]),
         .y_o     (pipe_y[i*X_W +: X_W]),
         .valid_o (pipe_valid[i]),
         .cross_o (cross_vec[i])
      );
   end

   always_comb begin
      inc = '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
         inc = inc + 4'(cross_vec[i]);
      end
   end

   assign step_sum = step_q + STEP_W'(inc);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      step_d  = step_q;
      pc_d    = pc_q;
      speed_d = speed_q;
      pass_d  = 1'b0;
      if (restart) begin
         state_d = LOAD;
         idx_d   = '0;
         step_d  = '0;
         pc_d    = '0;
         speed_d = 3'd1;
      end else begin
         case (state_q)
            LOAD: begin
               if (idx_q == IDX_W'(NUM_PIPES - 1)) begin
                  state_d = IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            IDLE: begin
               if (scroll) begin
                  state_d = RUN;
               end
            end
            RUN:     state_d = RUN;
            default: state_d = LOAD;
         endcase
         // inc is zero unless this is a scrolling tick.
         pass_d = (inc != '0);
         pc_d   = sat_add_count(pc_q, inc);
         step_d = step_sum;
         if (step_sum >= STEP_W'(SPEED_STEP)) begin
            step_d = step_sum - STEP_W'(SPEED_STEP);
            if (speed_q < 3'(SPEED_MAX)) begin
               speed_d = speed_q + 3'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= LOAD;
         idx_q   <= '0;
         step_q  <= '0;
         pc_q    <= '0;
         speed_q <= 3'd1;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         step_q  <= step_d;
         pc_q    <= pc_d;
         speed_q <= speed_d;
         pass_q  <= pass_d;
      end
   end

   assign pass       = pass_q;
   assign pass_count = pc_q;
   assign speed      = speed_q;

endmodule

// File: tb/tb_pipe_field_manager.sv
// Directed self-checking bench for pipe_field_manager with NUM_PIPES=2 and default geometry.
module tb_pipe_field_manager;

   localparam int NP = 2;
   localparam int XW = 11;

   logic             clk = 1'b0;
   logic             reset;
   logic             tick;
   logic             enable;
   logic             restart;
   logic [9:0]       random;
   logic [XW-1:0]    bird_x;
   logic [NP*XW-1:0] pipe_x;
   logic [NP*XW-1:0] pipe_y;
   logic [NP-1:0]    pipe_valid;
   logic             pass;
   logic [9:0]       pass_count;
   logic [2:0]       speed;

   int n_cmp = 0;
   int n_err = 0;

   pipe_field_manager #(
      .NUM_PIPES (NP),
      .X_W       (XW),
      .SCREEN_W  (640),
      .GAP_BASE  (200),
      .GAP_BITS  (8),
      .SPEED_MAX (4),
      .SPEED_STEP(8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .enable    (enable),
      .restart   (restart),
      .random    (random),
      .bird_x    (bird_x),
      .pipe_x    (pipe_x),
      .pipe_y    (pipe_y),
      .pipe_valid(pipe_valid),
      .pass      (pass),
      .pass_count(pass_count),
      .speed     (speed)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick1();
      tick   = 1'b1;
      enable = 1'b1;
      step();
      tick   = 1'b0;
   endtask

   task automatic run_to(input int target, input int budget);
      int n;
      n = 0;
      while (pass_count != 10'(target) && n < budget) begin
         tick1();
         n++;
      end
      chk("reach_pass_count", 32'(pass_count), 32'(target));
   endtask

   initial begin
      #10ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b0;
      tick    = 1'b0;
      enable  = 1'b0;
      restart = 1'b0;
      random  = 10'h03C;
      bird_x  = 11'd100;

      repeat (3) step();
      chk("rst_pipe_x", 32'(pipe_x), 32'd0);
      chk("rst_pipe_y", 32'(pipe_y), 32'd0);
      chk("rst_valid", 32'(pipe_valid), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_pass_count", 32'(pass_count), 32'd0);
      chk("rst_speed", 32'(speed), 32'd1);

      // Load: one slot per clock.
      reset = 1'b1;
      step();
      chk("load1_valid", 32'(pipe_valid), 32'b01);
      chk("load1_x0", 32'(pipe_x[10:0]), 32'd319);
      step();
      chk("load2_valid", 32'(pipe_valid), 32'b11);
      chk("load2_pipe_x", 32'(pipe_x), 32'({11'd639, 11'd319}));
      chk("load2_pipe_y", 32'(pipe_y), 32'({11'd320, 11'd260}));
      chk("load2_speed", 32'(speed), 32'd1);

      // IDLE: disabled tick ignored, enabled tick scrolls.
      tick = 1'b1; enable = 1'b0;
      step();
      tick = 1'b0;
      chk("idle_disabled_tick", 32'(pipe_x), 32'({11'd639, 11'd319}));
      tick1();
      chk("first_scroll", 32'(pipe_x), 32'({11'd638, 11'd318}));
      chk("first_scroll_pass", 32'(pass), 32'd0);
      tick = 1'b1; enable = 1'b0;
      step();
      tick = 1'b0;
      chk("run_disabled_tick", 32'(pipe_x), 32'({11'd638, 11'd318}));

      // Crossing the bird at x=100.
      repeat (217) tick1();
      chk("pre_cross_x0", 32'(pipe_x[10:0]), 32'd101);
      chk("pre_cross_count", 32'(pass_count), 32'd0);
      tick1();
      chk("cross_x0", 32'(pipe_x[10:0]), 32'd100);
      chk("cross_pass", 32'(pass), 32'd1);
      chk("cross_count", 32'(pass_count), 32'd1);
      step();
      chk("pass_one_clk", 32'(pass), 32'd0);
      tick1();
      chk("after_cross_x0", 32'(pipe_x[10:0]), 32'd99);
      chk("after_cross_pass", 32'(pass), 32'd0);
      chk("after_cross_count", 32'(pass_count), 32'd1);

      // Respawn from x=0 with a fresh gap.
      random = 10'h0A5;
      repeat (99) tick1();
      chk("at_zero_x0", 32'(pipe_x[10:0]), 32'd0);
      tick1();
      chk("respawn_x0", 32'(pipe_x[10:0]), 32'd639);
      chk("respawn_y0", 32'(pipe_y[10:0]), 32'd365);
      chk("respawn_x1", 32'(pipe_x[21:11]), 32'd319);
      chk("respawn_pass", 32'(pass), 32'd0);
      chk("respawn_count", 32'(pass_count), 32'd1);

      // Speed steps every 8 passes and saturates at 4.
      run_to(7, 5000);
      chk("speed_at_7", 32'(speed), 32'd1);
      run_to(8, 5000);
      chk("speed_at_8", 32'(speed), 32'd2);
      run_to(23, 5000);
      chk("speed_at_23", 32'(speed), 32'd3);
      run_to(24, 5000);
      chk("speed_at_24", 32'(speed), 32'd4);
      run_to(32, 5000);
      chk("speed_at_32", 32'(speed), 32'd4);
      run_to(40, 5000);
      chk("speed_at_40", 32'(speed), 32'd4);

      // Plain restart, then reload and run up to five passes.
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("restart1_valid", 32'(pipe_valid), 32'd0);
      chk("restart1_count", 32'(pass_count), 32'd0);
      chk("restart1_speed", 32'(speed), 32'd1);
      step();
      step();
      chk("reload1_pipe_x", 32'(pipe_x), 32'({11'd639, 11'd319}));
      run_to(5, 5000);

      // Restart with a simultaneous tick; ticks held high during LOAD are ignored.
      restart = 1'b1; tick = 1'b1; enable = 1'b1;
      step();
      restart = 1'b0;
      chk("restart2_count", 32'(pass_count), 32'd0);
      chk("restart2_speed", 32'(speed), 32'd1);
      chk("restart2_valid", 32'(pipe_valid), 32'd0);
      chk("restart2_pass", 32'(pass), 32'd0);
      step();
      chk("reload2_valid1", 32'(pipe_valid), 32'b01);
      chk("reload2_x0", 32'(pipe_x[10:0]), 32'd319);
      step();
      tick = 1'b0;
      chk("reload2_valid2", 32'(pipe_valid), 32'b11);
      chk("reload2_pipe_x", 32'(pipe_x), 32'({11'd639, 11'd319}));
      chk("reload2_count", 32'(pass_count), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_field_manager.md
Name: pipe_field_manager

Overview:
- Owns N scrolling pipe obstacles for the Flappy Bird game and supersedes the fixed two-pipe scroll logic.
- Parametrised pipe count; pipes initialise sequentially.
- Scroll speed rises with score; every pipe that passes the bird generates a pass event.
- Runs on the 50 MHz system clock and advances on a one-cycle game tick pulse. It feeds the display manager, the collision detector and the score manager.

Parameters:
- NUM_PIPES, 2, number of pipe slots (1..8).
- X_W, 11, coordinate width.
- SCREEN_W, 640, screen width in pixels; the respawn x is SCREEN_W-1.
- GAP_BASE, 200, base gap y; pipe y = GAP_BASE + random slice.
- GAP_BITS, 8, number of random bits added to GAP_BASE.
- SPEED_MAX, 4, maximum pixels per tick.
- SPEED_STEP, 8, passes required per speed increment.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle pulse per game frame.
- enable  in  1  game running (from game_manager); when low, ticks are ignored.
- restart  in  1  one-cycle pulse; reinitialises the field.
- random  in  10  LFSR value.
- bird_x  in  X_W  bird column.
- pipe_x  out  NUM_PIPES*X_W  packed pipe x values; slot i at [i*X_W +: X_W].
- pipe_y  out  NUM_PIPES*X_W  packed gap y values.
- pipe_valid  out  NUM_PIPES  slot has been loaded.
- pass  out  1  one-cycle pulse, asserted when at least one pipe crossed bird_x.
- pass_count  out  10  total passes since load; saturates at 1023.
- speed  out  3  current scroll speed.

Behaviour:
- States: LOAD, IDLE, RUN.
- Reset (reset=0):
  - state=LOAD, load index=0.
  - All pipe_x, pipe_y, pipe_valid, pass, pass_count = 0.
  - speed=1, step counter=0.
- LOAD: one slot per clk. Slot i gets:
  - x = (i+1)*(SCREEN_W/NUM_PIPES) - 1.
  - y = GAP_BASE + (random rotated left by i)[GAP_BITS-1:0].
  - pipe_valid[i] = 1.
  - After slot NUM_PIPES-1 the state goes to IDLE. Ticks are ignored during LOAD.
- IDLE: holds positions. Goes to RUN on the first tick with enable=1, and that tick also scrolls.
- RUN, on a tick with enable=1, each slot updates independently in the next cycle (latency 1 clk):
  - x==0: respawn with x=SCREEN_W-1 and new y from the rotated random as in LOAD.
  - x<speed: x=0.
  - otherwise: x=x-speed.
- RUN with enable=0: ticks are ignored and the state stays RUN (frozen field).
- Crossing rule: a slot crosses when old x > bird_x and new x <= bird_x. A respawning slot never counts as a crossing.
  - inc = number of slots crossing on this tick.
  - pass=1 for exactly one clk, in the same cycle the positions update.
  - pass_count += inc, saturating at 1023.
- Speed rule: the step counter adds inc. When the sum reaches SPEED_STEP or more:
  - subtract SPEED_STEP from the step counter;
  - speed += 1, saturating at SPEED_MAX. At most one speed increment per tick.
- Restart in any state, including mid-LOAD:
  - go to LOAD with index 0;
  - clear pass_count and the step counter; speed=1;
  - clear pipe_valid.
  - Restart takes priority over a simultaneous tick.
- Width rules:
  - All x arithmetic is X_W wide, unsigned; no underflow past 0.
  - y sum is X_W wide; the parameter choice guarantees GAP_BASE + 2^GAP_BITS - 1 < 2^X_W.

Decomposition:
- Package flappy_pkg holds:
  - X_W and SCREEN_W constants;
  - the state enum typedef {LOAD, IDLE, RUN};
  - a coord_t typedef (logic [X_W-1:0]).
- Sub-module pipe_slot, instantiated in a generate loop:
  - contains one slot's x/y registers, load, scroll/respawn and the cross-detect output;
  - the parent handles FSM sequencing, the popcount, pass_count and speed.

Test Plan:
- Reset then release, NUM_PIPES=2 -> after 2 clks pipe_x = {639, 319} (slot1, slot0), pipe_valid=2'b11, speed=1, state IDLE.
- Tick with enable=1, bird_x=100 -> next clk pipe_x = {638, 318}; a tick with enable=0 leaves x unchanged.
- Slot0 x=101, bird_x=100, speed=1, then tick -> x=100, pass high for 1 clk, pass_count=1; the next tick gives no pass.
- Slot0 x=0, random=10'h0A5, GAP_BASE=200, then tick -> x=639, y=200+8'hA5=365, no pass.
- 8 passes at SPEED_STEP=8 -> speed=2; continue to 32 passes -> speed=4; 40 passes -> speed stays 4.
- Restart asserted together with a tick mid-RUN (pass_count=5) -> LOAD; pass_count=0, speed=1; after 2 clks x values are 319/639 and the tick was ignored.
